// File: rtl/oam_dma_engine.sv
// OAM DMA engine: snoops CPU writes to $4014, halts the CPU and copies the
// 256-byte source page {PG,$00..$FF} to the PPU OAM data port at $2004 as
// alternating read/write bus cycles.
// Optional feature: define OAM_DMA_ALIGN_EN to insert an ALIGN cycle so that
// every READ lands on a "get" (P=0) cycle.
module oam_dma_engine (
  input  logic        i_clk_cpu,
  input  logic        i_rst,
  input  logic        i_cpu_wr,
  input  logic [15:0] i_cpu_addr,
  input  logic [7:0]  i_cpu_data,
  output logic        o_halt,
  output logic [15:0] o_addr,
  output logic        o_rnw,
  output logic        o_ce,
  input  logic [7:0]  i_data_in,
  output logic [7:0]  o_data_out,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } state_t;

  state_t     state, state_nx;
  logic [7:0] pg, pg_nx;
  logic [7:0] idx, idx_nx;
  logic [7:0] d, d_nx;
  logic       p;
  logic       trig;

  assign trig = (state == IDLE) && i_cpu_wr && (i_cpu_addr == 16'h4014);

  // Next-state, page/index and data-register update logic
  always_comb begin
    state_nx = state;
    pg_nx    = pg;
    idx_nx   = idx;
    d_nx     = d;
    case (state)
      IDLE: begin
        if (trig) begin
          state_nx = HALT;
          pg_nx    = i_cpu_data;
          idx_nx   = '0;
        end
      end
      HALT: begin
`ifdef OAM_DMA_ALIGN_EN
        // P=0 now means the following cycle is a put cycle; burn it in ALIGN
        state_nx = p ? READ : ALIGN;
`else
        state_nx = READ;
`endif
      end
      ALIGN: state_nx = READ;
      READ: begin
        state_nx = WRITE;
        d_nx     = i_data_in;
      end
      WRITE: begin
        idx_nx   = idx + 8'd1;
        state_nx = (idx == 8'hFF) ? IDLE : READ;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, page, index, data and parity registers
  always_ff @(posedge i_clk_cpu or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      pg    <= '0;
      idx   <= '0;
      d     <= '0;
      p     <= 1'b0;
    end else begin
      state <= state_nx;
      pg    <= pg_nx;
      idx   <= idx_nx;
      d     <= d_nx;
      p     <= ~p;
    end
  end

  // Registered bus/status outputs, decoded from the state being entered so
  // they line up with that state's cycle without any input-to-output path
  always_ff @(posedge i_clk_cpu or posedge i_rst) begin
    if (i_rst) begin
      o_halt     <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_addr     <= '0;
      o_rnw      <= 1'b1;
      o_ce       <= 1'b0;
      o_data_out <= '0;
    end else begin
      o_halt     <= (state_nx != IDLE);
      o_busy     <= (state_nx != IDLE);
      o_done     <= (state == WRITE) && (idx == 8'hFF);
      o_rnw      <= (state_nx != WRITE);
      o_ce       <= (state_nx == READ) && pg_nx[7];
      o_data_out <= (state_nx == WRITE) ? d_nx : '0;
      case (state_nx)
        READ:    o_addr <= {pg_nx, idx_nx};
        WRITE:   o_addr <= 16'h2004;
        default: o_addr <= '0;
      endcase
    end
  end

endmodule
